// File: rtl/regfile_pkg.sv
// Shared constants and clear-engine state encoding for the multiport register file.
package regfile_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_ZERO_REG = 0;
  localparam int DEF_BYPASS   = 1;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

  // Address width never collapses to zero, even for a 1-bit-addressable file.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Register file access bus: read ports, single write port and clear handshake.
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREAD = DEF_NREAD,
  parameter int AW    = addr_width(DEF_DEPTH)
);

  logic [NREAD-1:0][AW-1:0]    RA;
  logic [NREAD-1:0][WIDTH-1:0] RD;
  logic [AW-1:0]               WA;
  logic [WIDTH-1:0]            WD;
  logic                        WE3;
  logic                        clr_req;
  logic                        clr_busy;
  logic                        clr_done;

  modport master (
    output RA, WA, WD, WE3, clr_req,
    input  RD, clr_busy, clr_done
  );

  modport slave (
    input  RA, WA, WD, WE3, clr_req,
    output RD, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Sequential clear engine: sweeps every entry to zero, one per cycle, then pulses done.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = addr_width(DEF_DEPTH)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] idx,
  output logic          clr_we
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= CLR_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    busy     = 1'b0;
    done     = 1'b0;
    clr_we   = 1'b0;
    idx      = cnt;
    case (state)
      CLR_IDLE: begin
        if (start) begin
          state_nx = CLR_SWEEP;
          cnt_nx   = '0;
        end
      end
      CLR_SWEEP: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt == LAST) state_nx = CLR_DONE;
        else             cnt_nx   = cnt + AW'(1);
      end
      CLR_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = CLR_IDLE;
      end
      default: state_nx = CLR_IDLE;
    endcase
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with optional write-through bypass, hardwired zero entry
// and a sequential clear engine.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic                CLK,
  input  logic                reset,
  regfile_multiport_if.slave  bus
);

  localparam int            AW      = addr_width(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]            mem [DEPTH];
  logic                        busy;
  logic                        done;
  logic                        clr_we;
  logic [AW-1:0]               clr_idx;
  logic                        wr_ok;
  logic [AW-1:0]               ra;
  logic [NREAD-1:0][WIDTH-1:0] rd;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  regfile_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .CLK    (CLK),
    .reset  (reset),
    .start  (bus.clr_req),
    .busy   (busy),
    .done   (done),
    .idx    (clr_idx),
    .clr_we (clr_we)
  );

  // Only accepted writes may be stored or forwarded; busy covers both SWEEP and DONE.
  always_comb begin
    wr_ok = bus.WE3 && !busy && in_range(bus.WA) &&
            !((ZERO_REG != 0) && (bus.WA == '0));
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[bus.WA] <= bus.WD;
    end
  end

  // Zero-entry masking is applied last so it overrides the bypass path too.
  always_comb begin
    ra = '0;
    rd = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      ra = bus.RA[i];
      if (in_range(ra)) rd[i] = mem[ra];
      if ((BYPASS != 0) && wr_ok && (ra == bus.WA)) rd[i] = bus.WD;
      if ((ZERO_REG != 0) && (ra == '0)) rd[i] = '0;
    end
  end

  assign bus.RD       = rd;
  assign bus.clr_busy = busy;
  assign bus.clr_done = done;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: default config, no-bypass config and a DEPTH=6 zero-register config.
module tb_regfile_multiport;

  logic CLK;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  regfile_multiport_if #(.WIDTH(8), .NREAD(2), .AW(2)) bus_a ();
  regfile_multiport_if #(.WIDTH(8), .NREAD(2), .AW(2)) bus_b ();
  regfile_multiport_if #(.WIDTH(8), .NREAD(2), .AW(3)) bus_c ();

  regfile_multiport #(.WIDTH(8), .DEPTH(4), .NREAD(2), .ZERO_REG(0), .BYPASS(1))
    dut_a (.CLK(CLK), .reset(reset), .bus(bus_a));
  regfile_multiport #(.WIDTH(8), .DEPTH(4), .NREAD(2), .ZERO_REG(1), .BYPASS(0))
    dut_b (.CLK(CLK), .reset(reset), .bus(bus_b));
  regfile_multiport #(.WIDTH(8), .DEPTH(6), .NREAD(2), .ZERO_REG(1), .BYPASS(1))
    dut_c (.CLK(CLK), .reset(reset), .bus(bus_c));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus_a.RA = '0; bus_a.WA = '0; bus_a.WD = '0; bus_a.WE3 = 1'b0; bus_a.clr_req = 1'b0;
    bus_b.RA = '0; bus_b.WA = '0; bus_b.WD = '0; bus_b.WE3 = 1'b0; bus_b.clr_req = 1'b0;
    bus_c.RA = '0; bus_c.WA = '0; bus_c.WD = '0; bus_c.WE3 = 1'b0; bus_c.clr_req = 1'b0;
    repeat (2) tick();
    reset = 1'b1;

    // Reset state: every entry zero on both ports, engine idle
    #1;
    chk("rst_busy", 32'(bus_a.clr_busy), 32'h0);
    chk("rst_done", 32'(bus_a.clr_done), 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus_a.RA[0] = 2'(a);
      bus_a.RA[1] = 2'(a);
      #1;
      chk($sformatf("rst_rd0_%0d", a), 32'(bus_a.RD[0]), 32'h0);
      chk($sformatf("rst_rd1_%0d", a), 32'(bus_a.RD[1]), 32'h0);
    end

    // Same-cycle write/read: bypass on A, stored value on B
    tick();
    bus_a.WE3 = 1'b1; bus_a.WA = 2'd2; bus_a.WD = 8'hA5; bus_a.RA[0] = 2'd2; bus_a.RA[1] = 2'd1;
    bus_b.WE3 = 1'b1; bus_b.WA = 2'd2; bus_b.WD = 8'hA5; bus_b.RA[0] = 2'd2; bus_b.RA[1] = 2'd2;
    #2;
    chk("byp_a_rd0", 32'(bus_a.RD[0]), 32'hA5);
    chk("byp_a_rd1", 32'(bus_a.RD[1]), 32'h00);
    chk("nobyp_b_rd0", 32'(bus_b.RD[0]), 32'h00);
    chk("nobyp_b_rd1", 32'(bus_b.RD[1]), 32'h00);
    tick();
    bus_a.WE3 = 1'b0; bus_b.WE3 = 1'b0;
    #2;
    chk("after_a_rd0", 32'(bus_a.RD[0]), 32'hA5);
    chk("after_b_rd0", 32'(bus_b.RD[0]), 32'hA5);

    // Zero register on C: write to 0 dropped, bypass masked
    tick();
    bus_c.WE3 = 1'b1; bus_c.WA = 3'd0; bus_c.WD = 8'hFF; bus_c.RA[0] = 3'd0; bus_c.RA[1] = 3'd0;
    #2;
    chk("zr_wcyc_rd0", 32'(bus_c.RD[0]), 32'h00);
    chk("zr_wcyc_rd1", 32'(bus_c.RD[1]), 32'h00);
    tick();
    bus_c.WA = 3'd5; bus_c.WD = 8'h3C; bus_c.RA[1] = 3'd5;
    #2;
    chk("zr_after_rd0", 32'(bus_c.RD[0]), 32'h00);
    chk("c_byp_rd1", 32'(bus_c.RD[1]), 32'h3C);

    // Out-of-range write/read on DEPTH=6
    tick();
    bus_c.WA = 3'd7; bus_c.WD = 8'h5A; bus_c.RA[0] = 3'd7; bus_c.RA[1] = 3'd6;
    #2;
    chk("oor_wcyc_rd0", 32'(bus_c.RD[0]), 32'h00);
    chk("oor_wcyc_rd1", 32'(bus_c.RD[1]), 32'h00);
    tick();
    bus_c.WE3 = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_c.RA[0] = 3'(a);
      #1;
      chk($sformatf("c_scan_%0d", a), 32'(bus_c.RD[0]), (a == 5) ? 32'h3C : 32'h00);
    end

    // Fill A then sweep; a write mid-sweep must be dropped without bypass
    for (int a = 0; a < 4; a++) begin
      tick();
      bus_a.WE3 = 1'b1; bus_a.WA = 2'(a); bus_a.WD = 8'(8'h11 * (a + 1));
    end
    tick();
    bus_a.WE3 = 1'b0; bus_a.clr_req = 1'b1;
    #2;
    chk("req_cyc_busy", 32'(bus_a.clr_busy), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus_a.clr_req = (k == 3);
      bus_a.WE3 = (k == 2);
      bus_a.WA = 2'd3; bus_a.WD = 8'h77;
      bus_a.RA[0] = 2'd3;
      bus_a.RA[1] = (k == 2) ? 2'd0 : 2'd1;
      #2;
      chk($sformatf("sweep_busy_%0d", k), 32'(bus_a.clr_busy), 32'h1);
      chk($sformatf("sweep_done_%0d", k), 32'(bus_a.clr_done), (k == 5) ? 32'h1 : 32'h0);
      if (k == 2) begin
        chk("sweep_drop_nobyp", 32'(bus_a.RD[0]), 32'h44);
        chk("sweep_partial0", 32'(bus_a.RD[1]), 32'h00);
      end
      if (k == 3) begin
        chk("sweep_drop_kept", 32'(bus_a.RD[0]), 32'h44);
        chk("sweep_partial1", 32'(bus_a.RD[1]), 32'h00);
      end
    end
    tick();
    bus_a.clr_req = 1'b0; bus_a.WE3 = 1'b0;
    #2;
    chk("post_busy", 32'(bus_a.clr_busy), 32'h0);
    chk("post_done", 32'(bus_a.clr_done), 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus_a.RA[0] = 2'(a);
      #1;
      chk($sformatf("cleared_%0d", a), 32'(bus_a.RD[0]), 32'h00);
    end

    // clr_req together with a write in IDLE: write lands, then the sweep clears it
    tick();
    bus_a.clr_req = 1'b1; bus_a.WE3 = 1'b1; bus_a.WA = 2'd1; bus_a.WD = 8'h99;
    #2;
    chk("cw_req_busy", 32'(bus_a.clr_busy), 32'h0);
    tick();
    bus_a.clr_req = 1'b0; bus_a.WE3 = 1'b0; bus_a.RA[0] = 2'd1;
    #2;
    chk("cw_written", 32'(bus_a.RD[0]), 32'h99);
    chk("cw_busy", 32'(bus_a.clr_busy), 32'h1);
    repeat (4) tick();
    #2;
    chk("cw_done", 32'(bus_a.clr_done), 32'h1);
    tick();
    #2;
    chk("cw_cleared", 32'(bus_a.RD[0]), 32'h00);
    chk("cw_idle", 32'(bus_a.clr_busy), 32'h0);

    // Reset mid-sweep aborts with no done pulse; first edge after release accepts a write
    tick();
    bus_a.WE3 = 1'b1; bus_a.WA = 2'd1; bus_a.WD = 8'h5C;
    tick();
    bus_a.WA = 2'd3; bus_a.WD = 8'h6D;
    tick();
    bus_a.WE3 = 1'b0; bus_a.clr_req = 1'b1;
    tick();
    bus_a.clr_req = 1'b0;
    tick();
    bus_a.RA[0] = 2'd1; bus_a.RA[1] = 2'd3;
    #2;
    chk("ab_sweep2_rd1", 32'(bus_a.RD[0]), 32'h5C);
    chk("ab_sweep2_rd3", 32'(bus_a.RD[1]), 32'h6D);
    tick();
    reset = 1'b0;
    #1;
    chk("ab_busy", 32'(bus_a.clr_busy), 32'h0);
    chk("ab_done", 32'(bus_a.clr_done), 32'h0);
    chk("ab_rd1", 32'(bus_a.RD[0]), 32'h00);
    chk("ab_rd3", 32'(bus_a.RD[1]), 32'h00);
    tick();
    tick();
    reset = 1'b1;
    bus_a.WE3 = 1'b1; bus_a.WA = 2'd3; bus_a.WD = 8'hE1; bus_a.RA[0] = 2'd3;
    #2;
    chk("rel_busy", 32'(bus_a.clr_busy), 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      bus_a.WE3 = 1'b0;
      #2;
      chk($sformatf("rel_done_%0d", k), 32'(bus_a.clr_done), 32'h0);
      chk($sformatf("rel_rd_%0d", k), 32'(bus_a.RD[0]), 32'hE1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 Parameters SHALL be: WIDTH, 8, data bits per entry; DEPTH, 4, number of entries (2..256); NREAD, 2, number of read ports (1..4); ZERO_REG, 0, when 1 entry 0 reads as zero and ignores writes; BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
REQ-002 Derived constant AW SHALL be max(1, clog2(DEPTH)).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 RA  input  NREAD x AW  read address per port.
REQ-006 RD  output  NREAD x WIDTH  read data per port, combinational from RA.
REQ-007 WA  input  AW  write address.
REQ-008 WD  input  WIDTH  write data.
REQ-009 WE3  input  1  active-high write enable.
REQ-010 clr_req  input  1  single-cycle request to start a sequential clear of all entries.
REQ-011 clr_busy  output  1  high while the clear sweep runs.
REQ-012 clr_done  output  1  one-cycle pulse when the sweep completes.

Function
REQ-013 Write: when WE3=1, clr_busy=0 and WA<DEPTH, entry[WA] SHALL take WD at the rising edge.
REQ-014 Writes with WA>=DEPTH SHALL be dropped; reads with RA>=DEPTH SHALL return 0.
REQ-015 Read port i SHALL return entry[RA[i]] with zero-cycle latency.
REQ-016 With BYPASS=1, a port with RA[i]==WA during an accepted write SHALL return WD in that same cycle; with BYPASS=0 it SHALL return the old contents.
REQ-017 With ZERO_REG=1, writes to address 0 SHALL be dropped and all ports reading address 0 SHALL return 0, bypass included.
REQ-018 Clear engine states SHALL be IDLE, SWEEP, DONE.
REQ-019 IDLE -> SWEEP when clr_req=1; the sweep counter SHALL load 0.
REQ-020 In SWEEP, entry[counter] SHALL be written 0 each cycle and the counter incremented; SWEEP -> DONE after writing entry DEPTH-1 (exactly DEPTH cycles in SWEEP).
REQ-021 DONE SHALL last one cycle with clr_done=1, then return to IDLE.
REQ-022 clr_busy SHALL be 1 in SWEEP and DONE, 0 in IDLE.
REQ-023 External writes SHALL be dropped while clr_busy=1; bypass SHALL NOT apply to dropped writes.
REQ-024 clr_req while clr_busy=1 SHALL be ignored; clr_req and WE3 in the same IDLE cycle: the write SHALL complete, the sweep SHALL start next cycle and clear it.
REQ-025 Reads during SWEEP SHALL return current stored contents (partially cleared).

Reset
REQ-026 reset=0 SHALL asynchronously set all entries to 0, state to IDLE, counter to 0, clr_busy=0, clr_done=0.
REQ-027 reset asserted mid-sweep SHALL abort the sweep; no clr_done pulse SHALL follow.
REQ-028 Reset release SHALL be synchronous to CLK by the upstream reset synchroniser; the block SHALL accept a write on the first edge after release.

Structure
REQ-029 Clear-FSM state enum and default parameter constants SHALL live in shared package regfile_pkg.
REQ-030 The sweep FSM and counter SHALL be sub-module regfile_clr_seq (outputs: busy, done, clear index, clear write strobe); storage, bypass and read muxes SHALL stay in regfile_multiport.

Verification
REQ-031 Reset then read all 4 entries on both ports -> RD=0x00.
REQ-032 Write WA=2, WD=0xA5, RA[0]=2 same cycle -> RD[0]=0xA5 that cycle (BYPASS=1), old value with BYPASS=0; RD[0]=0xA5 next cycle both cases.
REQ-033 ZERO_REG=1, write WA=0 WD=0xFF -> RD at address 0 stays 0x00 in write cycle and after.
REQ-034 Fill entries with 0x11,0x22,0x33,0x44, pulse clr_req -> clr_busy high 5 cycles, clr_done high on 5th, all entries 0x00; write WD=0x77 during sweep is dropped.
REQ-035 DEPTH=6: write WA=7 WD=0x5A -> no entry changes, RA=7 reads 0x00.
REQ-036 Assert reset after 2 sweep cycles -> all entries 0, clr_busy=0, no clr_done pulse.
